// File: rtl/div_pkg.sv
// Shared definitions for the restoring array divider controller.
//   MASK_APPROX_STD : standard approximate-cell configuration of the 4x4 array
//   MASK_EXACT      : all cells exact
//   state_t         : controller FSM states
package div_pkg;

    localparam logic [15:0] MASK_APPROX_STD = 16'h8CEF;
    localparam logic [15:0] MASK_EXACT      = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_array_ctrl_array.sv
// Combinational 8/4 restoring array divider with per-cell approximation.
// Four rows, one per quotient bit (MSB first); each row holds four subtractor
// cells on bits 0..3 of the shifted partial remainder. Cell (row i, bit j) is
// controlled by a[i*4+j]:
//   a bit = 0 : exact full subtractor (diff = t^y^bin, borrow propagates)
//   a bit = 1 : approximate cell that ignores borrow-in (diff = t^y, bout = ~t&y)
// The caller guarantees x[7:4] < y and y != 0, so the quotient fits 4 bits.
// Ports:
//   x [7:0]  dividend        y [3:0]  divisor
//   a [15:0] approximation mask (0 = exact array)
//   q [3:0]  quotient        r [3:0]  remainder
module array (
    input  logic [7:0]  x,
    input  logic [3:0]  y,
    input  logic [15:0] a,
    output logic [3:0]  q,
    output logic [3:0]  r
);

    logic [3:0] rem;
    logic [4:0] t;
    logic [3:0] d;
    logic       b;
    logic       qb;

    always_comb begin
        rem = x[7:4];
        q   = '0;
        t   = '0;
        d   = '0;
        b   = 1'b0;
        qb  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t = {rem, x[3-i]};
            b = 1'b0;
            d = '0;
            for (int j = 0; j < 4; j++) begin
                if (a[i*4+j]) begin
                    d[j] = t[j] ^ y[j];
                    b    = ~t[j] & y[j];
                end else begin
                    d[j] = t[j] ^ y[j] ^ b;
                    b    = (~t[j] & y[j]) | (~(t[j] ^ y[j]) & b);
                end
            end
            // The fifth bit of the shifted remainder has no cell: if it is set
            // the subtraction always succeeds.
            qb       = t[4] | ~b;
            q[3-i]   = qb;
            rem      = qb ? d : t[3:0];
        end
        r = rem;
    end

endmodule

// File: rtl/restoring_array_ctrl.sv
// Sequencing controller for the 8/4 restoring array divider.
// Accepts a divide request, snapshots operands and the approximation mask,
// holds the combinational array stable for SETTLE cycles, registers the
// quotient/remainder and offers them as a response. Divide-by-zero and
// quotient overflow bypass the array and respond on the next cycle.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and its payload stable until that edge; ready
// may be raised or dropped freely. req_ready is high only in IDLE; rsp_valid is
// high only in DONE and all rsp_* are held until the handoff edge.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_dividend[7:0], req_divisor[3:0], req_approx   request payload
//   cfg_we, cfg_mask[15:0]          mask register write (any state)
//   mask_q[15:0]                    current mask register
//   rsp_valid/rsp_ready             response handshake
//   rsp_quot[3:0], rsp_rem[3:0], rsp_dbz, rsp_ovf, rsp_approx   response payload
//   busy                            controller not in IDLE
//   op_count[7:0]                   number of completed response handoffs (wraps)
module restoring_array_ctrl
    import div_pkg::*;
#(
    parameter int          SETTLE     = 2,               // legal range 1..15
    parameter logic [15:0] MASK_RESET = MASK_APPROX_STD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_dividend,
    input  logic [3:0]  req_divisor,
    input  logic        req_approx,
    input  logic        cfg_we,
    input  logic [15:0] cfg_mask,
    output logic [15:0] mask_q,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_quot,
    output logic [3:0]  rsp_rem,
    output logic        rsp_dbz,
    output logic        rsp_ovf,
    output logic        rsp_approx,
    output logic        busy,
    output logic [7:0]  op_count
);

    state_t      state;
    state_t      state_n;
    logic [3:0]  cnt;
    logic [7:0]  x_q;
    logic [3:0]  y_q;
    logic [15:0] a_q;
    logic [3:0]  arr_q;
    logic [3:0]  arr_r;

    logic        accept;
    logic        req_dbz;
    logic        req_ovf;
    logic        settle_last;

    // Array sees only the snapshot registers, so it is stable for all of RUN.
    array u_array (
        .x (x_q),
        .y (y_q),
        .a (a_q),
        .q (arr_q),
        .r (arr_r)
    );

    assign req_ready   = (state == IDLE);
    assign rsp_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign accept      = req_valid && req_ready;
    assign req_dbz     = (req_divisor == 4'd0);
    assign req_ovf     = !req_dbz && (req_dividend[7:4] >= req_divisor);
    assign settle_last = (cnt == 4'(SETTLE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = (req_dbz || req_ovf) ? DONE : RUN;
                end
            end
            RUN: begin
                if (settle_last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q     <= MASK_RESET;
            op_count   <= '0;
            cnt        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            a_q        <= '0;
            rsp_quot   <= '0;
            rsp_rem    <= '0;
            rsp_dbz    <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_approx <= 1'b0;
        end else begin
            // A write in the accept cycle lands after the snapshot below reads
            // the old mask_q, so the new value applies from the next request.
            if (cfg_we) begin
                mask_q <= cfg_mask;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_q        <= req_dividend;
                        y_q        <= req_divisor;
                        a_q        <= req_approx ? mask_q : MASK_EXACT;
                        cnt        <= '0;
                        rsp_approx <= req_approx;
                        rsp_dbz    <= req_dbz;
                        rsp_ovf    <= req_ovf;
                        rsp_quot   <= '0;
                        rsp_rem    <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 4'd1;
                    if (settle_last) begin
                        rsp_quot <= arr_q;
                        rsp_rem  <= arr_r;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        op_count <= op_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
